// File: rtl/msb_batch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : msb_batch_ctrl
// Brief    : Runs the MSB engine over COUNT testmem words (port 1), writing
//            each result to a destination region. Optional PERF counter is
//            enabled with `define MSB_BATCH_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module msb_batch_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DAT_W  = 32,
    parameter int CNT_W  = 11
) (
    input  logic              clk_gen,
    input  logic              srst,
    input  logic              cfg_we_i,
    input  logic              cfg_re_i,
    input  logic [2:0]        cfg_addr_i,
    input  logic [DAT_W-1:0]  cfg_wdata_i,
    output logic              cfg_resp_o,
    output logic [DAT_W-1:0]  cfg_rdata_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DAT_W-1:0]  mem_wdata_o,
    input  logic [DAT_W-1:0]  mem_rdata_i,
    output logic              eng_start_o,
    output logic [DAT_W-1:0]  eng_arg_o,
    input  logic              eng_done_i,
    input  logic [DAT_W-1:0]  eng_res_i,
    output logic              busy_o
);

    localparam logic [2:0] c_REG_CTRL  = 3'd0;
    localparam logic [2:0] c_REG_SRC   = 3'd1;
    localparam logic [2:0] c_REG_DST   = 3'd2;
    localparam logic [2:0] c_REG_COUNT = 3'd3;
    localparam logic [2:0] c_REG_PERF  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD    = 3'd1,
        S_RWAIT = 3'd2,
        S_EXEC  = 3'd3,
        S_EWAIT = 3'd4,
        S_WR    = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  r_idx;
    logic [DAT_W-1:0]  r_arg;
    logic [DAT_W-1:0]  r_res;
    logic [DAT_W-1:0]  r_rdata;
    logic              r_done;
    logic              r_aborted;
    logic              r_resp;

    logic              w_busy;
    logic              w_ctrl_wr;
    logic              w_start;
    logic              w_abort;
    logic              w_clr;
    logic              w_last;
    logic [ADDR_W-1:0] w_idx_a;
    logic [CNT_W-1:0]  w_idx_inc;
    logic [DAT_W-1:0]  w_rdata;
    logic              w_unused;

    assign w_busy    = (r_state != S_IDLE);
    assign w_ctrl_wr = cfg_we_i && (cfg_addr_i == c_REG_CTRL);
    assign w_start   = w_ctrl_wr && cfg_wdata_i[0] && !w_busy;
    assign w_abort   = w_ctrl_wr && cfg_wdata_i[1] && w_busy;
    assign w_clr     = w_ctrl_wr && cfg_wdata_i[2] && !w_busy;
    assign w_idx_a   = ADDR_W'(r_idx);
    assign w_idx_inc = r_idx + CNT_W'(1);
    assign w_last    = (w_idx_inc == r_count);
    assign w_unused  = ^cfg_wdata_i[DAT_W-1:CNT_W];

    always_ff @(posedge clk_gen) begin
        if (srst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        eng_start_o = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        case (r_state)
            S_IDLE: begin
                if (w_start && (r_count != '0)) begin
                    w_state_nxt = S_RD;
                end
            end
            S_RD: begin
                mem_addr_o  = r_src + w_idx_a;
                w_state_nxt = S_RWAIT;
            end
            S_RWAIT: begin
                w_state_nxt = S_EXEC;
            end
            S_EXEC: begin
                eng_start_o = 1'b1;
                w_state_nxt = S_EWAIT;
            end
            S_EWAIT: begin
                if (eng_done_i) begin
                    w_state_nxt = S_WR;
                end
            end
            S_WR: begin
                mem_we_o    = 1'b1;
                mem_addr_o  = r_dst + w_idx_a;
                w_state_nxt = w_last ? S_IDLE : S_RD;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        // An abort landing on a WR/EXEC cycle must not leak a write or a new engine job
        if (w_abort) begin
            w_state_nxt = S_IDLE;
            mem_we_o    = 1'b0;
            eng_start_o = 1'b0;
        end
    end

    always_ff @(posedge clk_gen) begin
        if (srst) begin
            r_src     <= '0;
            r_dst     <= '0;
            r_count   <= '0;
            r_idx     <= '0;
            r_arg     <= '0;
            r_res     <= '0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
        end else begin
            if (w_start) begin
                r_idx     <= '0;
                r_aborted <= 1'b0;
                r_done    <= (r_count == '0);
            end else if (w_clr) begin
                r_done    <= 1'b0;
                r_aborted <= 1'b0;
            end

            if (w_abort) begin
                r_aborted <= 1'b1;
                r_done    <= 1'b0;
            end else if (r_state == S_WR) begin
                r_idx <= w_idx_inc;
                if (w_last) begin
                    r_done <= 1'b1;
                end
            end

            if (r_state == S_RWAIT) begin
                r_arg <= mem_rdata_i;
            end
            if ((r_state == S_EWAIT) && eng_done_i) begin
                r_res <= eng_res_i;
            end

            if (cfg_we_i && !w_busy) begin
                case (cfg_addr_i)
                    c_REG_SRC:   r_src   <= cfg_wdata_i[ADDR_W-1:0];
                    c_REG_DST:   r_dst   <= cfg_wdata_i[ADDR_W-1:0];
                    c_REG_COUNT: r_count <= cfg_wdata_i[CNT_W-1:0];
                    default: ;
                endcase
            end
        end
    end

`ifdef MSB_BATCH_PERF_EN
    logic [31:0] r_perf;

    always_ff @(posedge clk_gen) begin
        if (srst) begin
            r_perf <= '0;
        end else if (w_start) begin
            r_perf <= '0;
        end else if (w_busy && (r_perf != 32'hFFFF_FFFF)) begin
            r_perf <= r_perf + 32'd1;
        end
    end
`endif

    always_comb begin
        w_rdata = '0;
        case (cfg_addr_i)
            c_REG_CTRL:  w_rdata = DAT_W'({r_aborted, r_done, w_busy});
            c_REG_SRC:   w_rdata = DAT_W'(r_src);
            c_REG_DST:   w_rdata = DAT_W'(r_dst);
            c_REG_COUNT: w_rdata = DAT_W'(r_count);
`ifdef MSB_BATCH_PERF_EN
            c_REG_PERF:  w_rdata = DAT_W'(r_perf);
`else
            c_REG_PERF:  w_rdata = '0;
`endif
            default:     w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk_gen) begin
        if (srst) begin
            r_resp  <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_resp  <= cfg_re_i;
            r_rdata <= cfg_re_i ? w_rdata : '0;
        end
    end

    assign cfg_resp_o  = r_resp;
    assign cfg_rdata_o = r_rdata;
    assign mem_wdata_o = r_res;
    assign eng_arg_o   = r_arg;
    assign busy_o      = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_msb_batch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_msb_batch_ctrl
// Brief    : Self-checking bench for msb_batch_ctrl with testmem/engine models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_msb_batch_ctrl;

`ifdef MSB_BATCH_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic        clk_gen = 1'b0;
    logic        srst    = 1'b1;
    logic        cfg_we  = 1'b0;
    logic        cfg_re  = 1'b0;
    logic [2:0]  cfg_addr  = '0;
    logic [31:0] cfg_wdata = '0;
    logic        cfg_resp;
    logic [31:0] cfg_rdata;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        eng_start;
    logic [31:0] eng_arg;
    logic        eng_done = 1'b0;
    logic [31:0] eng_res  = '0;
    logic        busy;

    always #5 clk_gen = ~clk_gen;

    msb_batch_ctrl #(.ADDR_W(10), .DAT_W(32), .CNT_W(11)) dut (
        .clk_gen     (clk_gen),
        .srst        (srst),
        .cfg_we_i    (cfg_we),
        .cfg_re_i    (cfg_re),
        .cfg_addr_i  (cfg_addr),
        .cfg_wdata_i (cfg_wdata),
        .cfg_resp_o  (cfg_resp),
        .cfg_rdata_o (cfg_rdata),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata),
        .eng_start_o (eng_start),
        .eng_arg_o   (eng_arg),
        .eng_done_i  (eng_done),
        .eng_res_i   (eng_res),
        .busy_o      (busy)
    );

    // Index of the highest set bit; 0 for a zero argument
    function automatic logic [31:0] msb(input logic [31:0] v);
        logic [32:0] w;
        w = {1'b0, v} + 33'd1;
        if (v == 32'd0) return 32'd0;
        return 32'($clog2(w) - 1);
    endfunction

    // testmem port 1: registered read, write on mem_we; pre_* is a backdoor preload
    logic [31:0] mem [0:1023];
    logic        pre_we   = 1'b0;
    logic [9:0]  pre_addr = '0;
    logic [31:0] pre_data = '0;
    always @(posedge clk_gen) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    // MSB engine: done arrives eng_delay cycles after the start cycle
    int          eng_delay = 1;
    int          e_cnt     = 0;
    logic [31:0] e_arg     = '0;
    always @(posedge clk_gen) begin
        eng_done <= 1'b0;
        if (eng_start) begin
            e_arg <= eng_arg;
            if (eng_delay == 1) begin
                eng_done <= 1'b1;
                eng_res  <= msb(eng_arg);
                e_cnt    <= 0;
            end else begin
                e_cnt <= eng_delay - 1;
            end
        end else if (e_cnt > 0) begin
            e_cnt <= e_cnt - 1;
            if (e_cnt == 1) begin
                eng_done <= 1'b1;
                eng_res  <= msb(e_arg);
            end
        end
    end

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          end_cyc = 0;
    bit          chk_en = 1'b0;
    logic [31:0] ref_mem [0:1023];
    logic [9:0]  exp_wr_addr [0:511];
    logic [31:0] exp_wr_data [0:511];
    logic [31:0] exp_arg [0:511];
    int          exp_wr_n = 0, wr_seen = 0, exp_arg_n = 0, arg_seen = 0;
    logic [31:0] last_arg = '0;
    logic [31:0] rd;
    int          n, k, cnt, dly;
    logic [9:0]  src, dst;
    logic [31:0] v;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic cycle_compare();
        check("busy", {31'd0, busy}, {31'd0, (cyc >= start_cyc) && (cyc < end_cyc)});
        if (mem_we) begin
            if (wr_seen >= exp_wr_n) begin
                check("unexpected_write", {31'd0, mem_we}, 32'd0);
            end else begin
                check("wr_addr", {22'd0, mem_addr}, {22'd0, exp_wr_addr[wr_seen]});
                check("wr_data", mem_wdata, exp_wr_data[wr_seen]);
                wr_seen++;
            end
        end
        if (eng_start) begin
            if (arg_seen >= exp_arg_n) begin
                check("unexpected_start", {31'd0, eng_start}, 32'd0);
            end else begin
                check("eng_arg", eng_arg, exp_arg[arg_seen]);
                arg_seen++;
            end
            last_arg = eng_arg;
        end
        if (eng_done && busy) check("arg_hold", eng_arg, last_arg);
    endtask

    task automatic tick();
        @(negedge clk_gen);
        if (chk_en) cycle_compare();
        @(posedge clk_gen);
        #1;
        cyc++;
    endtask

    task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic csr_chk(input string name, input logic [2:0] a, input logic [31:0] exp);
        cfg_re = 1'b1; cfg_addr = a;
        tick();
        cfg_re = 1'b0;
        check({name, "_resp"}, {31'd0, cfg_resp}, 32'd1);
        check(name, cfg_rdata, exp);
    endtask

    task automatic mem_set(input logic [9:0] a, input logic [31:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        ref_mem[a] = d;
        tick();
        pre_we = 1'b0;
    endtask

    task automatic configure(input logic [9:0] s, input logic [9:0] d, input logic [31:0] c);
        csr_wr(3'd1, {22'd0, s});
        csr_wr(3'd2, {22'd0, d});
        csr_wr(3'd3, c);
    endtask

    // Sequential reference: nw full elements, optionally one more element's read
    task automatic run_model(input logic [9:0] s, input logic [9:0] d, input int nw, input bit extra);
        logic [9:0]  a, w;
        logic [31:0] x, r;
        for (int i = 0; i < nw; i++) begin
            a = s + 10'(i);
            x = ref_mem[a];
            exp_arg[exp_arg_n] = x; exp_arg_n++;
            r = msb(x);
            w = d + 10'(i);
            ref_mem[w] = r;
            exp_wr_addr[exp_wr_n] = w; exp_wr_data[exp_wr_n] = r; exp_wr_n++;
        end
        if (extra) begin
            a = s + 10'(nw);
            exp_arg[exp_arg_n] = ref_mem[a]; exp_arg_n++;
        end
    endtask

    task automatic start_batch(input int len);
        start_cyc = cyc + 1;
        end_cyc   = start_cyc + len;
        csr_wr(3'd0, 32'h1);
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (busy && cycles < 2000) begin
            tick();
            cycles++;
        end
        check("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic drain_chk(input string name);
        check({name, "_writes"}, wr_seen, exp_wr_n);
        check({name, "_starts"}, arg_seen, exp_arg_n);
    endtask

    task automatic outputs_zero(input string name);
        check({name, "_we"},    {31'd0, mem_we},    32'd0);
        check({name, "_addr"},  {22'd0, mem_addr},  32'd0);
        check({name, "_wdata"}, mem_wdata,          32'd0);
        check({name, "_start"}, {31'd0, eng_start}, 32'd0);
        check({name, "_arg"},   eng_arg,            32'd0);
        check({name, "_busy"},  {31'd0, busy},      32'd0);
        check({name, "_resp"},  {31'd0, cfg_resp},  32'd0);
        check({name, "_rdata"}, cfg_rdata,          32'd0);
    endtask

    initial begin
        repeat (3) tick();
        srst = 1'b0;
        chk_en = 1'b1;
        outputs_zero("rst");
        csr_chk("rst_stat", 3'd0, 32'h0);
        csr_chk("rst_src", 3'd1, 32'h0);
        csr_chk("rst_cnt", 3'd3, 32'h0);
        csr_chk("rst_perf", 3'd4, 32'h0);
        csr_chk("unmapped", 3'd6, 32'h0);

        // Four-word batch, done one cycle after start
        eng_delay = 1;
        mem_set(10'h10, 32'h0000_0001);
        mem_set(10'h11, 32'h8000_0000);
        mem_set(10'h12, 32'h0001_0000);
        mem_set(10'h13, 32'h0000_FFFF);
        configure(10'h10, 10'h20, 32'd4);
        run_model(10'h10, 10'h20, 4, 1'b0);
        start_batch(20);
        wait_idle(n);
        check("t1_busy_len", n, 32'd20);
        csr_chk("t1_stat", 3'd0, 32'h2);
        check("t1_mem0", mem[10'h20], 32'd0);
        check("t1_mem1", mem[10'h21], 32'd31);
        check("t1_mem2", mem[10'h22], 32'd16);
        check("t1_mem3", mem[10'h23], 32'd15);
        csr_chk("t1_perf", 3'd4, PERF_ON ? 32'd20 : 32'd0);
        drain_chk("t1");

        // Zero-length batch
        configure(10'h10, 10'h20, 32'd0);
        start_batch(0);
        csr_chk("t2_stat", 3'd0, 32'h2);
        csr_chk("t2_perf", 3'd4, 32'h0);
        drain_chk("t2");

        // Abort (with START also set) during EWAIT of element 1
        eng_delay = 7;
        mem_set(10'h30, 32'h0000_0100);
        mem_set(10'h31, 32'h0000_0300);
        mem_set(10'h32, 32'h0000_0700);
        configure(10'h30, 10'h40, 32'd3);
        run_model(10'h30, 10'h40, 1, 1'b1);
        start_batch(33);
        n = 0; k = 0;
        while (k < 200) begin
            if (eng_start) n++;
            if (n == 2) break;
            tick();
            k++;
        end
        check("t3_second_start", n, 32'd2);
        tick();
        end_cyc = cyc + 1;
        csr_wr(3'd0, 32'h3);
        csr_chk("t3_stat", 3'd0, 32'h4);
        repeat (12) tick();
        csr_chk("t3_stat_late", 3'd0, 32'h4);
        check("t3_mem0", mem[10'h40], 32'd8);
        drain_chk("t3");

        // Address wrap with overlapping in-place regions
        eng_delay = 2;
        mem_set(10'h3FE, 32'hF000_0000);
        mem_set(10'h3FF, 32'h1234_5678);
        mem_set(10'h000, 32'h0000_0400);
        configure(10'h3FE, 10'h3FF, 32'd3);
        run_model(10'h3FE, 10'h3FF, 3, 1'b0);
        start_batch(18);
        wait_idle(n);
        csr_chk("t4_stat", 3'd0, 32'h2);
        check("t4_mem3ff", mem[10'h3FF], 32'd31);
        check("t4_mem000", mem[10'h000], 32'd4);
        check("t4_mem001", mem[10'h001], 32'd2);
        drain_chk("t4");

        // Writes while busy are ignored
        eng_delay = 1;
        configure(10'h10, 10'h20, 32'd4);
        run_model(10'h10, 10'h20, 4, 1'b0);
        start_batch(20);
        csr_wr(3'd0, 32'h1);
        csr_wr(3'd1, 32'h55);
        csr_wr(3'd3, 32'd9);
        csr_wr(3'd0, 32'h4);
        csr_chk("t5_stat_busy", 3'd0, 32'h1);
        csr_chk("t5_src_busy", 3'd1, 32'h10);
        csr_chk("t5_cnt_busy", 3'd3, 32'd4);
        wait_idle(n);
        csr_chk("t5_stat", 3'd0, 32'h2);
        csr_chk("t5_src", 3'd1, 32'h10);
        csr_chk("t5_cnt", 3'd3, 32'd4);
        csr_wr(3'd0, 32'h4);
        csr_chk("t5_stat_clr", 3'd0, 32'h0);
        drain_chk("t5");

        // Randomized batches
        for (int it = 0; it < 8; it++) begin
            src = 10'($urandom_range(0, 1023));
            dst = 10'($urandom_range(0, 1023));
            cnt = $urandom_range(1, 6);
            dly = $urandom_range(1, 4);
            eng_delay = dly;
            for (int i = 0; i < cnt; i++) begin
                v = $urandom >> $urandom_range(0, 31);
                if (v == 32'd0) v = 32'd1;
                mem_set(src + 10'(i), v);
            end
            configure(src, dst, cnt);
            run_model(src, dst, cnt, 1'b0);
            start_batch(cnt * (4 + dly));
            wait_idle(n);
            csr_chk("rnd_stat", 3'd0, 32'h2);
            csr_chk("rnd_perf", 3'd4, PERF_ON ? 32'(cnt * (4 + dly)) : 32'd0);
            for (int i = 0; i < cnt; i++) begin
                check("rnd_mem", mem[dst + 10'(i)], ref_mem[dst + 10'(i)]);
            end
            drain_chk("rnd");
        end

        // Reset in the middle of a batch
        eng_delay = 1;
        configure(10'h10, 10'h20, 32'd4);
        run_model(10'h10, 10'h20, 4, 1'b0);
        start_batch(20);
        repeat (7) tick();
        srst = 1'b1;
        end_cyc = cyc + 1;
        tick();
        exp_wr_n  = wr_seen;
        exp_arg_n = arg_seen;
        outputs_zero("t6");
        srst = 1'b0;
        tick();
        csr_chk("t6_stat", 3'd0, 32'h0);
        csr_chk("t6_src", 3'd1, 32'h0);
        csr_chk("t6_cnt", 3'd3, 32'h0);
        repeat (5) tick();
        drain_chk("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
